// File: rtl/alu_mc.sv
// Purpose : multi-cycle ALU; simple ops in one pass, iterative unsigned MULTU/DIVU writing HI/LO.
// Latency : simple ops and DIVU-by-zero finish one cycle after accept; MULTU/DIVU after WIDTH+1 cycles.
// Backpr. : none; start is honoured only in IDLE, and a start in any other state is dropped.
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] num_1,
  input  logic [WIDTH-1:0] num_2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADDU  = 4'h0;
  localparam logic [3:0] OP_SUBU  = 4'h1;
  localparam logic [3:0] OP_AND   = 4'h2;
  localparam logic [3:0] OP_OR    = 4'h3;
  localparam logic [3:0] OP_XOR   = 4'h4;
  localparam logic [3:0] OP_NOR   = 4'h5;
  localparam logic [3:0] OP_SLT   = 4'h6;
  localparam logic [3:0] OP_SLTU  = 4'h7;
  localparam logic [3:0] OP_SLL   = 4'h8;
  localparam logic [3:0] OP_SRL   = 4'h9;
  localparam logic [3:0] OP_SRA   = 4'hA;
  localparam logic [3:0] OP_MULTU = 4'hB;
  localparam logic [3:0] OP_DIVU  = 4'hC;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  state_t               state;
  // MUL: {partial product high, multiplier/low product}; DIV: {remainder, dividend/quotient}
  logic [2*WIDTH-1:0]   acc;
  // latched num_2: multiplicand for MULTU, divisor for DIVU
  logic [WIDTH-1:0]     opnd_b;
  logic [SHW-1:0]       iter;

  logic [SHW-1:0]       shamt;
  logic [WIDTH-1:0]     simple_res;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH:0]       div_shift;
  logic [WIDTH:0]       div_diff;
  logic                 div_ge;
  logic [WIDTH-1:0]     div_rem;
  logic [2*WIDTH-1:0]   div_next;
  logic                 last_iter;

  assign shamt     = num_2[SHW-1:0];
  // WIDTH is a power of two, so the final iteration index is all ones
  assign last_iter = (iter == {SHW{1'b1}});

  // Single-pass ops evaluated straight from the ports on the accept edge
  always_comb begin
    simple_res = '0;
    case (op)
      OP_ADDU: simple_res = num_1 + num_2;
      OP_SUBU: simple_res = num_1 - num_2;
      OP_AND:  simple_res = num_1 & num_2;
      OP_OR:   simple_res = num_1 | num_2;
      OP_XOR:  simple_res = num_1 ^ num_2;
      OP_NOR:  simple_res = ~(num_1 | num_2);
      OP_SLT:  simple_res = {{(WIDTH-1){1'b0}}, ($signed(num_1) < $signed(num_2))};
      OP_SLTU: simple_res = {{(WIDTH-1){1'b0}}, (num_1 < num_2)};
      OP_SLL:  simple_res = num_1 << shamt;
      OP_SRL:  simple_res = num_1 >> shamt;
      OP_SRA:  simple_res = $unsigned($signed(num_1) >>> shamt);
      default: simple_res = '0;
    endcase
  end

  // One shift-add step: add the multiplicand into the high half when the current LSB is set, then shift right
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd_b : {WIDTH{1'b0}})};
    mul_next = {mul_sum, acc[WIDTH-1:1]};
  end

  // One restoring-division step: shift in the next dividend bit, subtract if it fits, record the quotient bit
  always_comb begin
    div_shift = acc[2*WIDTH-1:WIDTH-1];
    div_diff  = div_shift - {1'b0, opnd_b};
    // remainder stays below the divisor, so bit WIDTH of the difference is a clean borrow
    div_ge    = ~div_diff[WIDTH];
    div_rem   = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    div_next  = {div_rem, acc[WIDTH-2:0], div_ge};
  end

  // Control FSM with registered status and result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      acc         <= '0;
      opnd_b      <= '0;
      iter        <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= '0;
      zero        <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            zero        <= (num_1 == num_2);
            div_by_zero <= 1'b0;
            iter        <= '0;
            acc         <= {{WIDTH{1'b0}}, num_1};
            opnd_b      <= num_2;
            case (op)
              OP_MULTU: begin
                state <= S_MUL;
                busy  <= 1'b1;
              end
              OP_DIVU: begin
                if (num_2 == '0) begin
                  state       <= S_FIN;
                  done        <= 1'b1;
                  result      <= {WIDTH{1'b1}};
                  lo          <= {WIDTH{1'b1}};
                  hi          <= num_1;
                  div_by_zero <= 1'b1;
                end else begin
                  state <= S_DIV;
                  busy  <= 1'b1;
                end
              end
              default: begin
                // illegal opcodes land here too and yield 0 through simple_res
                state  <= S_FIN;
                done   <= 1'b1;
                result <= simple_res;
              end
            endcase
          end
        end
        S_MUL: begin
          acc  <= mul_next;
          iter <= iter + {{(SHW-1){1'b0}}, 1'b1};
          if (last_iter) begin
            state  <= S_FIN;
            busy   <= 1'b0;
            done   <= 1'b1;
            hi     <= mul_next[2*WIDTH-1:WIDTH];
            lo     <= mul_next[WIDTH-1:0];
            result <= mul_next[WIDTH-1:0];
          end
        end
        S_DIV: begin
          acc  <= div_next;
          iter <= iter + {{(SHW-1){1'b0}}, 1'b1};
          if (last_iter) begin
            state  <= S_FIN;
            busy   <= 1'b0;
            done   <= 1'b1;
            hi     <= div_next[2*WIDTH-1:WIDTH];
            lo     <= div_next[WIDTH-1:0];
            result <= div_next[WIDTH-1:0];
          end
        end
        S_FIN: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc: scoreboard of expected results pushed at issue, popped on done.
module tb_alu_mc;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [3:0]   op;
  logic [W-1:0] num_1;
  logic [W-1:0] num_2;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         div_by_zero;

  alu_mc #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .num_1(num_1), .num_2(num_2),
    .busy(busy), .done(done), .result(result), .zero(zero), .hi(hi), .lo(lo),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] res;
    logic         zf;
    logic [W-1:0] hv;
    logic [W-1:0] lv;
    logic         dbz;
    logic [7:0]   lat;
  } exp_t;

  exp_t         sb_q[$];
  string        tag_q[$];
  int           total  = 0;
  int           passed = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Reference model: pushes the expected outcome and drives the request
  task automatic issue(input string tag, input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t        e;
    logic [63:0] p;
    e.res = '0; e.zf = (a == b); e.dbz = 1'b0; e.lat = 8'd1;
    case (o)
      4'h0: e.res = a + b;
      4'h1: e.res = a - b;
      4'h2: e.res = a & b;
      4'h3: e.res = a | b;
      4'h4: e.res = a ^ b;
      4'h5: e.res = ~(a | b);
      4'h6: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'h7: e.res = (a < b) ? 32'd1 : 32'd0;
      4'h8: e.res = a << b[4:0];
      4'h9: e.res = a >> b[4:0];
      4'hA: e.res = $unsigned($signed(a) >>> b[4:0]);
      4'hB: begin
        p = {32'd0, a} * {32'd0, b};
        m_hi = p[63:32]; m_lo = p[31:0]; e.res = m_lo; e.lat = 8'd33;
      end
      4'hC: begin
        if (b == 0) begin
          m_lo = 32'hFFFF_FFFF; m_hi = a; e.dbz = 1'b1;
        end else begin
          m_lo = a / b; m_hi = a % b; e.lat = 8'd33;
        end
        e.res = m_lo;
      end
      default: e.res = '0;
    endcase
    e.hv = m_hi; e.lv = m_lo;
    sb_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
    start = 1'b1; op = o; num_1 = a; num_2 = b;
    @(posedge clk);
  endtask

  // Waits for done after the accept edge, then compares against the scoreboard head
  task automatic run(input int spur, input bit fin_pulse);
    int    n = 0;
    int    busy_cnt = 0;
    int    extra = 0;
    bit    seen = 1'b0;
    bit    both = 1'b0;
    exp_t  e;
    string t;
    while (!seen && n < 100) begin
      @(negedge clk);
      n++;
      if (n == 1) start = 1'b0;
      if (busy) busy_cnt++;
      if (busy && done) both = 1'b1;
      if (spur > 1 && n == spur) begin
        start = 1'b1; op = 4'h0; num_1 = $urandom; num_2 = $urandom;
      end
      if (spur > 1 && n == spur + 1) start = 1'b0;
      if (done) seen = 1'b1;
    end
    if (sb_q.size() == 0) begin
      chk("scoreboard_empty", 64'(sb_q.size()), 64'd1);
      return;
    end
    e = sb_q.pop_front();
    t = tag_q.pop_front();
    chk({t, "_done_seen"}, 64'(seen), 64'd1);
    chk({t, "_latency"}, 64'(n), 64'(e.lat));
    chk({t, "_busy_cycles"}, 64'(busy_cnt), 64'(e.lat) - 64'd1);
    chk({t, "_busy_done_overlap"}, 64'(both), 64'd0);
    chk({t, "_result"}, 64'(result), 64'(e.res));
    chk({t, "_zero"}, 64'(zero), 64'(e.zf));
    chk({t, "_hi"}, 64'(hi), 64'(e.hv));
    chk({t, "_lo"}, 64'(lo), 64'(e.lv));
    chk({t, "_div_by_zero"}, 64'(div_by_zero), 64'(e.dbz));
    if (fin_pulse) begin
      start = 1'b1; op = 4'h0; num_1 = 32'd1; num_2 = 32'd1;
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) extra++;
    end
    chk({t, "_extra_done"}, 64'(extra), 64'd0);
  endtask

  initial begin
    int dn;
    rst = 1'b1; start = 1'b0; op = '0; num_1 = '0; num_2 = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_zero", 64'(zero), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_dbz", 64'(div_by_zero), 64'd0);
    rst = 1'b0;

    issue("addu_wrap", 4'h0, 32'hFFFF_FFFF, 32'd1);        run(0, 0);
    issue("subu_eq",   4'h1, 32'd5, 32'd5);                run(0, 0);
    issue("and",       4'h2, 32'hF0F0_1234, 32'h0FF0_FF00); run(0, 0);
    issue("or",        4'h3, 32'hF0F0_1234, 32'h0FF0_FF00); run(0, 0);
    issue("xor",       4'h4, 32'hF0F0_1234, 32'h0FF0_FF00); run(0, 0);
    issue("nor",       4'h5, 32'hF0F0_1234, 32'h0FF0_FF00); run(0, 0);
    issue("slt",       4'h6, 32'hFFFF_FFFF, 32'd1);        run(0, 0);
    issue("sltu",      4'h7, 32'hFFFF_FFFF, 32'd1);        run(0, 0);
    issue("sll0",      4'h8, 32'hDEAD_BEEF, 32'hFFFF_FFE0); run(0, 0);
    issue("sll31",     4'h8, 32'h0000_0003, 32'd31);       run(0, 0);
    issue("srl",       4'h9, 32'h8000_0000, 32'd4);        run(0, 0);
    issue("sra",       4'hA, 32'h8000_0000, 32'd4);        run(0, 0);
    chk("sra_const", 64'(result), 64'h0000_0000_F800_0000);

    issue("multu_max", 4'hB, 32'hFFFF_FFFF, 32'hFFFF_FFFF); run(5, 1);
    chk("multu_hi_const", 64'(hi), 64'h0000_0000_FFFF_FFFE);
    chk("multu_lo_const", 64'(lo), 64'd1);
    issue("illegal_d", 4'hD, 32'd7, 32'd7);                run(0, 0);
    issue("addu_keep_hilo", 4'h0, 32'd3, 32'd4);           run(0, 0);

    issue("divu_100_7", 4'hC, 32'd100, 32'd7);             run(0, 0);
    chk("divu_lo_const", 64'(lo), 64'd14);
    chk("divu_hi_const", 64'(hi), 64'd2);
    issue("divu_by0",  4'hC, 32'd9, 32'd0);                run(0, 0);
    issue("addu_clr_dbz", 4'h0, 32'd1, 32'd2);             run(0, 0);

    for (int i = 0; i < 3; i++) begin
      issue("multu_rnd", 4'hB, $urandom, $urandom);        run(0, 0);
      issue("divu_rnd", 4'hC, $urandom, 32'($urandom_range(1, 65535))); run(0, 0);
    end

    // reset during the tenth DIVU iteration aborts it
    issue("divu_abort", 4'hC, 32'd1000, 32'd3);
    void'(sb_q.pop_back());
    void'(tag_q.pop_back());
    dn = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (done) dn++;
    end
    rst = 1'b1;
    @(negedge clk);
    m_hi = '0; m_lo = '0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_result", 64'(result), 64'd0);
    chk("abort_zero", 64'(zero), 64'd0);
    chk("abort_hi", 64'(hi), 64'd0);
    chk("abort_lo", 64'(lo), 64'd0);
    chk("abort_dbz", 64'(div_by_zero), 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("abort_no_done", 64'(dn), 64'd0);
    issue("addu_after_abort", 4'h0, 32'd10, 32'd20);       run(0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
